// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : UART transmitter with built-in baud divider and a TX FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DATA_BITS-1:0]        wr_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    output logic                        busy,
    output logic                        tx
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = $clog2(STOP_BITS * DIV) + 1;
    localparam int IW  = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] c_BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] c_STOP_LAST = CW'(STOP_BITS * DIV - 1);
    localparam logic [IW-1:0] c_IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [LW-1:0] c_DEPTH     = LW'(FIFO_DEPTH);
    localparam logic          c_ODD       = (PARITY == 1);

    generate
        if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
            $error("uart_tx_fifo: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [DATA_BITS-1:0]   sh_q;
    logic                   par_q;
    logic                   tx_q;
    logic                   busy_q;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [LW-1:0]          level_q;
    logic [LW-1:0]          level_d;
    logic                   full_q;
    logic                   empty_q;
    logic                   overflow_q;
    logic                   w_push;
    logic                   w_pop;

    // full is the pre-edge flag, so a same-cycle pop never rescues a push into a full FIFO
    always_comb begin
        w_push  = wr_en & ~full_q;
        w_pop   = (state_q == ST_IDLE) & ~empty_q;
        level_d = level_q;
        if (w_push && !w_pop) begin
            level_d = level_q + LW'(1);
        end else if (!w_push && w_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            full_q     <= (level_d == c_DEPTH);
            empty_q    <= (level_d == '0);
            overflow_q <= wr_en & full_q;
        end
    end

    // tx and busy are registered from the current state, so the line trails the FSM by one clock
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_q != ST_IDLE) | ~empty_q;
            unique case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty_q) begin
                        sh_q    <= mem_q[rd_ptr_q];
                        par_q   <= (^mem_q[rd_ptr_q]) ^ c_ODD;
                        cnt_q   <= '0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    tx_q <= 1'b0;
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    tx_q <= sh_q[0];
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q <= '0;
                        sh_q  <= sh_q >> 1;
                        idx_q <= idx_q + IW'(1);
                        if (idx_q == c_IDX_LAST) begin
                            state_q <= (PARITY != 0) ? ST_PAR : ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_PAR: begin
                    tx_q <= par_q;
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (cnt_q == c_STOP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign tx       = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Three uart_tx_fifo configurations driven by shared stimulus and
//             checked every cycle against a line-timeline reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DIV = 10;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;

    logic       a_full  [3];
    logic       a_empty [3];
    logic       a_ovf   [3];
    logic       a_busy  [3];
    logic       a_tx    [3];
    logic [2:0] lvl0;
    logic [2:0] lvl1;
    logic [3:0] lvl2;

    // Per-instance configuration: 8N1/depth4, 8E2/depth4, 8O1/depth8
    int c_par [3] = '{0, 2, 1};
    int c_stp [3] = '{1, 2, 1};
    int c_dep [3] = '{4, 4, 8};
    logic c_lit_8n1 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(a_full[0]), .empty(a_empty[0]), .level(lvl0),
        .overflow(a_ovf[0]), .busy(a_busy[0]), .tx(a_tx[0]));

    uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(a_full[1]), .empty(a_empty[1]), .level(lvl1),
        .overflow(a_ovf[1]), .busy(a_busy[1]), .tx(a_tx[1]));

    uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(a_full[2]), .empty(a_empty[2]), .level(lvl2),
        .overflow(a_ovf[2]), .busy(a_busy[2]), .tx(a_tx[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL timeout %s: bound expired at t=%0t", name, $time);
    endtask

    function automatic logic [31:0] act_lvl(input int i);
        case (i)
            0:       return {29'd0, lvl0};
            1:       return {29'd0, lvl1};
            default: return {28'd0, lvl2};
        endcase
    endfunction

    // Reference model: FIFO contents plus the time of the last pop; the line
    // waveform after edge k is frame bit (k-pop-1)/DIV while inside the frame.
    int         edge_k = 0;
    logic [7:0] mq [3][8];
    int         mhead [3];
    int         mcnt [3];
    int         pop_t [3] = '{-1, -1, -1};
    int         ready_t [3];
    int         flen [3];
    logic [15:0] fr [3];
    logic       e_tx [3];
    logic       e_ovf [3];
    logic       e_busy [3];
    int         e_level [3];

    task automatic model_step();
        int   pl;
        bit   act;
        int   nb;
        logic [7:0] d;
        edge_k++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mcnt[i]    = 0;
                mhead[i]   = 0;
                pop_t[i]   = -1;
                ready_t[i] = edge_k + 1;
                e_tx[i]    = 1'b1;
                e_ovf[i]   = 1'b0;
                e_busy[i]  = 1'b0;
            end else begin
                pl  = mcnt[i];
                act = (pop_t[i] >= 0) && (edge_k > pop_t[i]) && (edge_k <= pop_t[i] + flen[i]);
                e_busy[i] = act || (pl > 0);
                e_tx[i]   = act ? fr[i][(edge_k - pop_t[i] - 1) / DIV] : 1'b1;
                e_ovf[i]  = wr_en && (pl == c_dep[i]);
                if (wr_en && pl < c_dep[i]) begin
                    mq[i][(mhead[i] + pl) % c_dep[i]] = wr_data;
                    mcnt[i]++;
                end
                if (pl > 0 && edge_k >= ready_t[i]) begin
                    d        = mq[i][mhead[i]];
                    mhead[i] = (mhead[i] + 1) % c_dep[i];
                    mcnt[i]--;
                    fr[i]    = '0;
                    nb       = 1;
                    for (int j = 0; j < 8; j++) begin
                        fr[i][nb] = d[j];
                        nb++;
                    end
                    if (c_par[i] != 0) begin
                        fr[i][nb] = (c_par[i] == 2) ? ^d : ~^d;
                        nb++;
                    end
                    for (int s = 0; s < c_stp[i]; s++) begin
                        fr[i][nb] = 1'b1;
                        nb++;
                    end
                    flen[i]    = nb * DIV;
                    pop_t[i]   = edge_k;
                    ready_t[i] = edge_k + flen[i] + 1;
                end
            end
            e_level[i] = mcnt[i];
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (edge_k > 0) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.tx", i),       {31'd0, a_tx[i]},    {31'd0, e_tx[i]});
                chk($sformatf("u%0d.busy", i),     {31'd0, a_busy[i]},  {31'd0, e_busy[i]});
                chk($sformatf("u%0d.overflow", i), {31'd0, a_ovf[i]},   {31'd0, e_ovf[i]});
                chk($sformatf("u%0d.level", i),    act_lvl(i),          e_level[i]);
                chk($sformatf("u%0d.empty", i),    {31'd0, a_empty[i]}, {31'd0, e_level[i] == 0});
                chk($sformatf("u%0d.full", i),     {31'd0, a_full[i]},  {31'd0, e_level[i] == c_dep[i]});
            end
        end
    end

    function automatic bit model_idle();
        for (int i = 0; i < 3; i++) begin
            if (mcnt[i] != 0 || edge_k < ready_t[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (!model_idle() && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) timeout_fail("wait_idle");
        repeat (3) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ov [3];
        int t;
        int prev;
        int lows;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        // Reset held while wr_en toggles
        repeat (4) begin
            @(negedge clk);
            chk("rst_tx",    {31'd0, a_tx[0]},    1);
            chk("rst_empty", {31'd0, a_empty[0]}, 1);
            chk("rst_level", {29'd0, lvl0},       0);
            chk("rst_busy",  {31'd0, a_busy[0]},  0);
            chk("rst_ovf",   {31'd0, a_ovf[0]},   0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom);
        end
        rst_n = 1'b1;
        wr_en = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte 0xA5 on the 8N1 instance: literal line pattern
        push(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(posedge clk);
        for (int b = 0; b < 10; b++) begin
            repeat (5) @(posedge clk);
            #1;
            chk("lit_8n1_bit", {31'd0, a_tx[0]}, {31'd0, c_lit_8n1[b]});
            if (b == 9) chk("lit_busy_in_stop", {31'd0, a_busy[0]}, 1);
            repeat (5) @(posedge clk);
        end
        #1;
        chk("lit_busy_drop", {31'd0, a_busy[0]}, 0);
        @(negedge clk);
        wait_idle();

        // 0x07: even parity bit 1, odd parity bit 0
        push(8'h07);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (97) @(posedge clk);
        #1;
        chk("lit_even_parity", {31'd0, a_tx[1]}, 1);
        chk("lit_odd_parity",  {31'd0, a_tx[2]}, 0);
        @(negedge clk);
        wait_idle();

        // Burst of six into depth-4 FIFOs
        for (int i = 0; i < 3; i++) ov[i] = 0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) ov[i] += int'(a_ovf[i]);
            if (j <= 6) begin
                wr_en   = 1'b1;
                wr_data = 8'(j);
            end else begin
                wr_en = 1'b0;
            end
        end
        chk("lit_ovf_pulses_u0", ov[0], 1);
        chk("lit_ovf_pulses_u1", ov[1], 1);
        chk("lit_ovf_pulses_u2", ov[2], 0);
        wait_idle();

        // Push landing on the 8N1 instance's IDLE pop edge with level 2
        push(8'h11);
        push(8'h22);
        push(8'h33);
        @(negedge clk);
        wr_en = 1'b0;
        t = 0;
        while (edge_k < ready_t[0] - 1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) timeout_fail("pop_edge");
        chk("lit_level_before_pop", {29'd0, lvl0}, 2);
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        chk("lit_level_after_simul", {29'd0, lvl0}, 2);
        wait_idle();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rst_n   = ($urandom_range(0, 399) != 0);
            wr_en   = ($urandom_range(0, 4) == 0);
            wr_data = 8'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0;
        wait_idle();

        // Reset during data bit 3 of the 8N1 frame
        prev = pop_t[0];
        push(8'h3C);
        push(8'hC3);
        @(negedge clk);
        wr_en = 1'b0;
        t = 0;
        while (!(pop_t[0] != prev && edge_k >= pop_t[0] + 44) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) timeout_fail("mid_frame");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("lit_midrst_tx",    {31'd0, a_tx[0]},    1);
        chk("lit_midrst_level", {29'd0, lvl0},       0);
        chk("lit_midrst_empty", {31'd0, a_empty[0]}, 1);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            lows += int'(!a_tx[0]);
        end
        chk("lit_midrst_no_frames", lows, 0);
        chk("lit_midrst_busy", {31'd0, a_busy[0]}, 0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
